// File: rtl/color_manager_porch_sequencer.sv
// Line porch sequencer: walks BACK -> ACTIVE -> FRONT from latched lengths after a Sync edge,
// with optional auto-repeat, mid-line resync and a freeze-on-disable behaviour.
module color_manager_porch_sequencer #(
  parameter int unsigned BACKPORCH_WIDTH  = 8,
  parameter int unsigned FRONTPORCH_WIDTH = 8,
  parameter int unsigned ACTIVE_WIDTH     = 11,
  parameter int unsigned CNT_WIDTH        = 11,
  parameter bit          RESYNC           = 1'b1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Enable,
  input  logic                        Sync,
  input  logic                        AutoRepeat,
  input  logic [BACKPORCH_WIDTH-1:0]  BackPorch,
  input  logic [ACTIVE_WIDTH-1:0]     ActiveLen,
  input  logic [FRONTPORCH_WIDTH-1:0] FrontPorch,
  output logic [1:0]                  Phase,
  output logic                        Counter_Valid,
  output logic [CNT_WIDTH-1:0]        CounterP,
  output logic                        Line_Done,
  output logic                        Sync_Err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } phase_t;

  phase_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] back_q, back_d;
  logic [CNT_WIDTH-1:0] act_q, act_d;
  logic [CNT_WIDTH-1:0] front_q, front_d;
  logic                 prev_q, prev_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [CNT_WIDTH-1:0] in_back, in_act, in_front;
  logic                 sync_edge;
  logic                 do_start;

  assign in_back   = CNT_WIDTH'(BackPorch);
  assign in_act    = CNT_WIDTH'(ActiveLen);
  assign in_front  = CNT_WIDTH'(FrontPorch);
  assign sync_edge = Sync & ~prev_q;

  // Normal starts (idle or last cycle) win over resync; auto-repeat only fires on the last cycle.
  assign do_start = (sync_edge && ((state_q == IDLE) || last_q || RESYNC)) ||
                    (last_q && AutoRepeat);

  function automatic logic [CNT_WIDTH-1:0] len_of(input phase_t ph,
                                                  input logic [CNT_WIDTH-1:0] b,
                                                  input logic [CNT_WIDTH-1:0] a,
                                                  input logic [CNT_WIDTH-1:0] f);
    logic [CNT_WIDTH-1:0] r;
    r = '0;
    case (ph)
      BACK:    r = b;
      ACTIVE:  r = a;
      FRONT:   r = f;
      default: r = '0;
    endcase
    return r;
  endfunction

  // First non-empty phase strictly after ph; IDLE when none remain.
  function automatic phase_t next_nz(input phase_t ph,
                                     input logic [CNT_WIDTH-1:0] b,
                                     input logic [CNT_WIDTH-1:0] a,
                                     input logic [CNT_WIDTH-1:0] f);
    phase_t r;
    r = IDLE;
    if ((ph == IDLE) && (b != '0))
      r = BACK;
    else if (((ph == IDLE) || (ph == BACK)) && (a != '0))
      r = ACTIVE;
    else if ((ph != FRONT) && (f != '0))
      r = FRONT;
    return r;
  endfunction

  function automatic logic is_last(input phase_t ph,
                                   input logic [CNT_WIDTH-1:0] cnt,
                                   input logic [CNT_WIDTH-1:0] b,
                                   input logic [CNT_WIDTH-1:0] a,
                                   input logic [CNT_WIDTH-1:0] f);
    return (ph != IDLE) &&
           (cnt == len_of(ph, b, a, f) - CNT_WIDTH'(1)) &&
           (next_nz(ph, b, a, f) == IDLE);
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    back_d  = back_q;
    act_d   = act_q;
    front_d = front_q;
    prev_d  = prev_q;
    last_d  = last_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (Enable) begin
      prev_d = Sync;
      err_d  = sync_edge && (state_q != IDLE) && !last_q;

      if (do_start) begin
        back_d  = in_back;
        act_d   = in_act;
        front_d = in_front;
        state_d = next_nz(IDLE, in_back, in_act, in_front);
        cnt_d   = '0;
        // An all-zero line is complete the moment it starts.
        last_d  = (state_d == IDLE) ||
                  is_last(state_d, '0, in_back, in_act, in_front);
      end else if (last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = 1'b0;
      end else if (state_q != IDLE) begin
        if (cnt_q == len_of(state_q, back_q, act_q, front_q) - CNT_WIDTH'(1)) begin
          state_d = next_nz(state_q, back_q, act_q, front_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        last_d = is_last(state_d, cnt_d, back_q, act_q, front_q);
      end

      valid_d = (state_d == ACTIVE);
      done_d  = last_d;
    end
  end

  // State and output registers; previous-Sync resets high so a held Sync is not an edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      back_q  <= '0;
      act_q   <= '0;
      front_q <= '0;
      prev_q  <= 1'b1;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      back_q  <= back_d;
      act_q   <= act_d;
      front_q <= front_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Phase         = state_q;
  assign CounterP      = cnt_q;
  assign Counter_Valid = valid_q;
  assign Line_Done     = done_q;
  assign Sync_Err      = err_q;

endmodule

// File: tb/tb_color_manager_porch_sequencer.sv
// Scoreboard bench for color_manager_porch_sequencer: expected per-cycle outputs are queued
// when a line is launched and popped one per clock as the DUT steps through it.
module tb_color_manager_porch_sequencer;

  localparam int unsigned CW = 11;

  typedef struct packed {
    logic [1:0]    ph;
    logic [CW-1:0] cnt;
    logic          cv;
    logic          ld;
    logic          err;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Rst, Enable, Sync, AutoRepeat;
  logic [7:0]    BackPorch, FrontPorch;
  logic [10:0]   ActiveLen;
  logic [1:0]    Phase, Phase0;
  logic          Counter_Valid, Counter_Valid0;
  logic [CW-1:0] CounterP, CounterP0;
  logic          Line_Done, Line_Done0;
  logic          Sync_Err, Sync_Err0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  exp_t q0[$];
  exp_t e, got;
  int   k;

  always #5 Clk = ~Clk;

  color_manager_porch_sequencer #(.RESYNC(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Sync(Sync), .AutoRepeat(AutoRepeat),
    .BackPorch(BackPorch), .ActiveLen(ActiveLen), .FrontPorch(FrontPorch),
    .Phase(Phase), .Counter_Valid(Counter_Valid), .CounterP(CounterP),
    .Line_Done(Line_Done), .Sync_Err(Sync_Err)
  );

  color_manager_porch_sequencer #(.RESYNC(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Sync(Sync), .AutoRepeat(AutoRepeat),
    .BackPorch(BackPorch), .ActiveLen(ActiveLen), .FrontPorch(FrontPorch),
    .Phase(Phase0), .Counter_Valid(Counter_Valid0), .CounterP(CounterP0),
    .Line_Done(Line_Done0), .Sync_Err(Sync_Err0)
  );

  function automatic exp_t mk(input logic [1:0] ph, input int cnt, input logic ld, input logic err);
    exp_t r;
    r.ph  = ph;
    r.cnt = CW'(cnt);
    r.cv  = (ph == 2'd2);
    r.ld  = ld;
    r.err = err;
    return r;
  endfunction

  function automatic exp_t obs();
    exp_t r;
    r = {Phase, CounterP, Counter_Valid, Line_Done, Sync_Err};
    return r;
  endfunction

  function automatic exp_t obs0();
    exp_t r;
    r = {Phase0, CounterP0, Counter_Valid0, Line_Done0, Sync_Err0};
    return r;
  endfunction

  task automatic push_item(input exp_t x, input bit to0);
    if (to0) q0.push_back(x);
    else     q.push_back(x);
  endtask

  // Expected cycles of one line, from the cycle after its start to its last cycle.
  task automatic push_line(input int b, input int a, input int f, input bit to0);
    int len[3];
    int lastp;
    len[0] = b; len[1] = a; len[2] = f;
    lastp = -1;
    for (int p = 0; p < 3; p++) if (len[p] != 0) lastp = p;
    if (lastp < 0) push_item(mk(2'd0, 0, 1'b1, 1'b0), to0);
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < len[p]; c++)
        push_item(mk(2'(p + 1), c, (p == lastp) && (c == len[p] - 1), 1'b0), to0);
  endtask

  task automatic push_idle(input int n, input bit to0);
    for (int i = 0; i < n; i++) push_item(mk(2'd0, 0, 1'b0, 1'b0), to0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Rst = 1'b0; Sync = 1'b0; Enable = 1'b1; AutoRepeat = 1'b0;
    repeat (2) step();
    Rst = 1'b1;
    repeat (2) step();
    q.delete();
    q0.delete();
    k = 0;
  endtask

  task automatic start_line(input int b, input int a, input int f);
    BackPorch  = 8'(b);
    ActiveLen  = 11'(a);
    FrontPorch = 8'(f);
    Sync       = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; Sync = 1'b1; Enable = 1'b1; AutoRepeat = 1'b1;
    BackPorch = 8'd1; ActiveLen = 11'd4; FrontPorch = 8'd8;
    repeat (2) step();
    e = mk(2'd0, 0, 1'b0, 1'b0);
    got = obs();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset: got %p required %p", got, e); end
    got = obs0();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_r0: got %p required %p", got, e); end
  endtask

  task automatic test_basic();
    apply_reset();
    start_line(1, 4, 8);
    push_line(1, 4, 8, 1'b0);
    push_idle(2, 1'b0);
    while (q.size() > 0) begin
      step(); k++;
      Sync = 1'b0;
      BackPorch = 8'd3; ActiveLen = 11'd7; FrontPorch = 8'd2;
      e = q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL basic t+%0d: got %p required %p", k, got, e); end
    end
  endtask

  task automatic test_zero_skip();
    apply_reset();
    start_line(0, 3, 0);
    push_line(0, 3, 0, 1'b0);
    push_idle(2, 1'b0);
    while (q.size() > 0) begin
      step(); k++;
      Sync = 1'b0;
      e = q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL zero_skip t+%0d: got %p required %p", k, got, e); end
    end
    k = 0;
    start_line(0, 0, 0);
    push_line(0, 0, 0, 1'b0);
    push_idle(2, 1'b0);
    while (q.size() > 0) begin
      step(); k++;
      Sync = 1'b0;
      e = q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL all_zero t+%0d: got %p required %p", k, got, e); end
    end
  endtask

  task automatic test_resync();
    apply_reset();
    start_line(1, 4, 8);
    push_line(1, 4, 8, 1'b0);
    while (q.size() > 3) void'(q.pop_back());
    push_line(1, 4, 8, 1'b0);
    q[3].err = 1'b1;
    push_idle(2, 1'b0);
    push_line(1, 4, 8, 1'b1);
    q0[3].err = 1'b1;
    push_idle(2, 1'b1);
    while ((q.size() > 0) || (q0.size() > 0)) begin
      step(); k++;
      Sync = (k == 3);
      if (q.size() > 0) begin
        e = q.pop_front(); got = obs(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL resync1 t+%0d: got %p required %p", k, got, e); end
      end
      if (q0.size() > 0) begin
        e = q0.pop_front(); got = obs0(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL resync0 t+%0d: got %p required %p", k, got, e); end
      end
    end
  endtask

  task automatic test_sync_at_end();
    apply_reset();
    start_line(1, 4, 8);
    push_line(1, 4, 8, 1'b0);
    push_line(0, 2, 1, 1'b0);
    push_idle(2, 1'b0);
    while (q.size() > 0) begin
      step(); k++;
      Sync = (k == 13);
      if (k == 12) begin BackPorch = 8'd0; ActiveLen = 11'd2; FrontPorch = 8'd1; end
      e = q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL sync_at_end t+%0d: got %p required %p", k, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    AutoRepeat = 1'b1;
    start_line(1, 4, 8);
    repeat (3) push_line(1, 4, 8, 1'b0);
    push_line(2, 2, 2, 1'b0);
    push_idle(2, 1'b0);
    while (q.size() > 0) begin
      step(); k++;
      Sync = 1'b0;
      if (k == 30) begin BackPorch = 8'd2; ActiveLen = 11'd2; FrontPorch = 8'd2; end
      if (k == 41) AutoRepeat = 1'b0;
      e = q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL back_to_back t+%0d: got %p required %p", k, got, e); end
    end
  endtask

  task automatic test_enable_freeze();
    exp_t hold;
    apply_reset();
    start_line(1, 4, 8);
    push_line(1, 4, 8, 1'b0);
    hold = q[7];
    for (int i = 0; i < 5; i++) q.insert(8, hold);
    push_idle(2, 1'b0);
    while (q.size() > 0) begin
      step(); k++;
      Sync   = (k == 10) || (k == 11);
      Enable = !((k >= 8) && (k <= 12));
      e = q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL enable_freeze t+%0d: got %p required %p", k, got, e); end
    end
    Enable = 1'b1;
  endtask

  task automatic test_reset_midline();
    apply_reset();
    start_line(1, 4, 8);
    push_line(1, 4, 8, 1'b0);
    while (q.size() > 3) void'(q.pop_back());
    push_idle(6, 1'b0);
    push_line(1, 4, 8, 1'b0);
    push_idle(2, 1'b0);
    while (q.size() > 0) begin
      step(); k++;
      Rst  = !(k == 3);
      Sync = !(k == 8);
      e = q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL reset_midline t+%0d: got %p required %p", k, got, e); end
    end
    Sync = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; Enable = 1'b1; Sync = 1'b0; AutoRepeat = 1'b0;
    BackPorch = '0; ActiveLen = '0; FrontPorch = '0;
    k = 0;
    test_reset();
    test_basic();
    test_zero_skip();
    test_resync();
    test_sync_at_end();
    test_back_to_back();
    test_enable_freeze();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
